// File: rtl/joypad_scheduler.sv
// NES pad poller and FF00 joypad register: runs the strobe/shift sequence on the pad,
// commits the button byte, muxes it into FF00 by the select bits and raises an irq on falls.
//
// state  | meaning
// IDLE   | waiting for a scheduled or requested poll
// STROBE | latch pulse high, pad captures its buttons
// LO     | shift clock low; last cycle samples the current bit
// HI     | shift clock high; pad advances to the next bit
// DONE   | commit shadow byte to buttons for one cycle
`timescale 1ns/1ps
module joypad_scheduler #(
   parameter int POLL_DIV   = 204800,
   parameter int STROBE_CYC = 12,
   parameter int HALF_BIT   = 6
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ctrl_data,
   output logic       ctrl_strobe,
   output logic       ctrl_clk,
   input  logic       poll_now,
   input  logic       reg_we,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       joypad_irq
);

   localparam int PW     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int PH_MAX = (STROBE_CYC > HALF_BIT) ? STROBE_CYC : HALF_BIT;
   localparam int CW     = $clog2(PH_MAX) + 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] HALF_LD   = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_STROBE, S_LO, S_HI, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
   logic            pending_q, pending_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shadow_q, shadow_d;
   logic            strobe_q, clk_q, valid_q, irq_q;
   logic [7:0]      buttons_q;
   logic [1:0]      sel_q;
   logic [3:0]      prev_nib_q;
   logic [3:0]      nib;
   logic            trigger, start_req;
   logic            unused_wdata;

   assign unused_wdata = ^{reg_wdata[7:6], reg_wdata[3:0]};

   assign trigger    = (poll_cnt_q == POLL_LAST);
   assign poll_cnt_d = trigger ? '0 : poll_cnt_q + PW'(1);
   assign start_req  = pending_q | trigger | poll_now;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      pending_d = start_req;
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d   = S_STROBE;
               cnt_d     = STROBE_LD;
               pending_d = 1'b0;
            end
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               state_d = S_LO;
               cnt_d   = HALF_LD;
               idx_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_LO: begin
            if (cnt_q == '0) begin
               shadow_d[idx_q] = ~ctrl_data;
               cnt_d           = HALF_LD;
               state_d         = (idx_q == 3'd7) ? S_DONE : S_HI;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HI: begin
            if (cnt_q == '0) begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = HALF_LD;
               state_d = S_LO;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Action row is {start,select,b,a}; direction row is {down,up,left,right}.
   always_comb begin
      nib = 4'hF;
      if (!sel_q[1]) nib = nib & ~buttons_q[3:0];
      if (!sel_q[0]) nib = nib & ~{buttons_q[5], buttons_q[4], buttons_q[6], buttons_q[7]};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         poll_cnt_q <= '0;
         pending_q  <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         shadow_q   <= 8'h00;
         strobe_q   <= 1'b0;
         clk_q      <= 1'b0;
         valid_q    <= 1'b0;
         buttons_q  <= 8'h00;
         irq_q      <= 1'b0;
         sel_q      <= 2'b11;
         prev_nib_q <= 4'hF;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         strobe_q   <= (state_d == S_STROBE);
         clk_q      <= (state_d == S_HI);
         valid_q    <= (state_d == S_DONE);
         // shadow_d already carries bit 7 sampled on the entering edge
         if (state_d == S_DONE) buttons_q <= shadow_d;
         irq_q      <= |(prev_nib_q & ~nib);
         prev_nib_q <= nib;
         if (reg_we) sel_q <= reg_wdata[5:4];
      end
   end

   assign ctrl_strobe   = strobe_q;
   assign ctrl_clk      = clk_q;
   assign buttons_valid = valid_q;
   assign buttons       = buttons_q;
   assign joypad_irq    = irq_q;
   assign reg_rdata     = {2'b11, sel_q, nib};

endmodule

// File: tb/tb_joypad_scheduler.sv
// Directed bench for joypad_scheduler with a behavioural shift-register pad model.
`timescale 1ns/1ps
module tb_joypad_scheduler;
   localparam int POLL_DIV   = 200;
   localparam int STROBE_CYC = 4;
   localparam int HALF_BIT   = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ctrl_data, ctrl_strobe, ctrl_clk;
   logic       poll_now = 1'b0, reg_we = 1'b0;
   logic [7:0] reg_wdata = 8'h00;
   logic [7:0] reg_rdata, buttons;
   logic       buttons_valid, joypad_irq;

   int errors = 0;
   int checks = 0;

   logic [7:0] pad_pressed = 8'h81;
   logic [2:0] sh_idx = 3'd0;
   logic       clk_d = 1'b0, strb_d = 1'b0;
   int         cyc = 0, clk_rises = 0, strobe_rises = 0, valid_cnt = 0, irq_cnt = 0;

   joypad_scheduler #(.POLL_DIV(POLL_DIV), .STROBE_CYC(STROBE_CYC), .HALF_BIT(HALF_BIT)) dut (
      .clock(clock), .reset_n(reset_n), .ctrl_data(ctrl_data), .ctrl_strobe(ctrl_strobe),
      .ctrl_clk(ctrl_clk), .poll_now(poll_now), .reg_we(reg_we), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .buttons(buttons), .buttons_valid(buttons_valid),
      .joypad_irq(joypad_irq)
   );

   always #5 clock = ~clock;

   // Pad: strobe reloads bit 0 (A); each ctrl_clk rise shifts to the next button.
   assign ctrl_data = ~pad_pressed[sh_idx];

   always @(posedge clock) begin
      cyc    <= reset_n ? cyc + 1 : 0;
      clk_d  <= ctrl_clk;
      strb_d <= ctrl_strobe;
      if (ctrl_strobe === 1'b1) sh_idx <= 3'd0;
      else if (ctrl_clk === 1'b1 && !clk_d) sh_idx <= sh_idx + 3'd1;
      if (ctrl_clk === 1'b1 && !clk_d) clk_rises <= clk_rises + 1;
      if (ctrl_strobe === 1'b1 && !strb_d) strobe_rises <= strobe_rises + 1;
      if (buttons_valid === 1'b1) valid_cnt <= valid_cnt + 1;
      if (joypad_irq === 1'b1) irq_cnt <= irq_cnt + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_sel(input logic [7:0] d);
      reg_wdata = d;
      reg_we    = 1'b1;
      tick();
      reg_we    = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      checks++; if (ctrl_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", ctrl_strobe); end
      checks++; if (ctrl_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b expected 0", ctrl_clk); end
      checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL rst_buttons: got %h expected 00", buttons); end
      checks++; if (buttons_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", buttons_valid); end
      checks++; if (joypad_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", joypad_irq); end
      checks++; if (reg_rdata !== 8'hFF) begin errors++; $display("FAIL rst_rdata: got %h expected FF", reg_rdata); end
      reset_n = 1'b1;
   endtask

   task automatic test_idle_start();
      int bad;
      int width;
      bad = 0;
      for (int i = 1; i <= 199; i++) begin
         tick();
         if (ctrl_strobe !== 1'b0 || ctrl_clk !== 1'b0 || reg_rdata !== 8'hFF) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
      tick();
      checks++; if (ctrl_strobe !== 1'b1) begin errors++; $display("FAIL strobe_start: got %b expected 1", ctrl_strobe); end
      width = 1;
      for (int off = 1; off <= 3; off++) begin
         tick();
         if (ctrl_strobe === 1'b1) width++;
      end
      tick();
      checks++; if (width != 4) begin errors++; $display("FAIL strobe_width: got %0d expected 4", width); end
      checks++; if (ctrl_strobe !== 1'b0) begin errors++; $display("FAIL strobe_end: got %b expected 0", ctrl_strobe); end
   endtask

   task automatic test_poll_a_right();
      int r0, v0, first;
      r0 = clk_rises; v0 = valid_cnt; first = -1;
      for (int off = 5; off <= 40; off++) begin
         tick();
         if (buttons_valid === 1'b1 && first < 0) first = off;
      end
      checks++; if (first != 34) begin errors++; $display("FAIL valid_offset: got %0d expected 34", first); end
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL valid_pulses: got %0d expected 1", valid_cnt - v0); end
      checks++; if (clk_rises - r0 != 7) begin errors++; $display("FAIL clk_rises: got %0d expected 7", clk_rises - r0); end
      checks++; if (buttons !== 8'h81) begin errors++; $display("FAIL buttons_a_right: got %h expected 81", buttons); end
      write_sel(8'h10);
      checks++; if (reg_rdata !== 8'hDE) begin errors++; $display("FAIL rdata_sel01: got %h expected DE", reg_rdata); end
      write_sel(8'h20);
      checks++; if (reg_rdata !== 8'hEE) begin errors++; $display("FAIL rdata_sel10: got %h expected EE", reg_rdata); end
   endtask

   task automatic test_irq_start();
      int i0, voff, ioff;
      write_sel(8'h10);
      repeat (2) tick();
      checks++; if (reg_rdata !== 8'hDE) begin errors++; $display("FAIL irq_pre_rdata: got %h expected DE", reg_rdata); end
      pad_pressed = 8'h08;
      i0 = irq_cnt; voff = -1; ioff = -1;
      poll_now = 1'b1; tick(); poll_now = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (buttons_valid === 1'b1 && voff < 0) voff = n;
         if (joypad_irq === 1'b1 && ioff < 0) ioff = n;
      end
      checks++; if (voff < 0 || ioff != voff + 1) begin errors++; $display("FAIL irq_delay: got irq at %0d valid at %0d expected valid+1", ioff, voff); end
      checks++; if (irq_cnt - i0 != 1) begin errors++; $display("FAIL irq_once: got %0d pulses expected 1", irq_cnt - i0); end
      checks++; if (reg_rdata !== 8'hD7) begin errors++; $display("FAIL rdata_start: got %h expected D7", reg_rdata); end
      pad_pressed = 8'h00;
      i0 = irq_cnt;
      poll_now = 1'b1; tick(); poll_now = 1'b0;
      repeat (45) tick();
      checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL buttons_release: got %h expected 00", buttons); end
      checks++; if (reg_rdata !== 8'hDF) begin errors++; $display("FAIL rdata_release: got %h expected DF", reg_rdata); end
      checks++; if (irq_cnt - i0 != 0) begin errors++; $display("FAIL irq_on_rise: got %0d pulses expected 0", irq_cnt - i0); end
   endtask

   task automatic test_back_to_back();
      int n, s0, v0, second, vfirst;
      logic prev;
      pad_pressed = 8'h24;
      n = 0;
      while (cyc % POLL_DIV != 180 && n < 500) begin tick(); n++; end
      checks++; if (cyc % POLL_DIV != 180 || ctrl_strobe !== 1'b0) begin errors++; $display("FAIL b2b_align: got cyc %0d strobe %b expected phase 180 idle", cyc, ctrl_strobe); end
      s0 = strobe_rises; v0 = valid_cnt;
      poll_now = 1'b1; tick(); poll_now = 1'b0;
      checks++; if (ctrl_strobe !== 1'b1) begin errors++; $display("FAIL b2b_first_start: got %b expected 1", ctrl_strobe); end
      prev = 1'b1; second = -1; vfirst = -1;
      for (int off = 1; off <= 80; off++) begin
         poll_now = (off == 4 || off == 9 || off == 14);
         tick();
         if (ctrl_strobe === 1'b1 && !prev && second < 0) second = off;
         prev = ctrl_strobe;
         if (buttons_valid === 1'b1 && vfirst < 0) vfirst = off;
      end
      poll_now = 1'b0;
      checks++; if (vfirst != 34) begin errors++; $display("FAIL b2b_done: got %0d expected 34", vfirst); end
      checks++; if (second != 36) begin errors++; $display("FAIL b2b_restart: got %0d expected 36", second); end
      checks++; if (strobe_rises - s0 != 2) begin errors++; $display("FAIL b2b_polls: got %0d expected 2", strobe_rises - s0); end
      checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_commits: got %0d expected 2", valid_cnt - v0); end
   endtask

   task automatic test_reset_mid_poll();
      int v0, first;
      pad_pressed = 8'hFF;
      poll_now = 1'b1; tick(); poll_now = 1'b0;
      for (int off = 1; off <= 22; off++) tick();
      checks++; if (ctrl_clk !== 1'b1) begin errors++; $display("FAIL mid_hi_phase: got %b expected 1", ctrl_clk); end
      v0 = valid_cnt;
      reset_n = 1'b0;
      tick();
      checks++; if (ctrl_clk !== 1'b0) begin errors++; $display("FAIL abort_clk: got %b expected 0", ctrl_clk); end
      checks++; if (ctrl_strobe !== 1'b0) begin errors++; $display("FAIL abort_strobe: got %b expected 0", ctrl_strobe); end
      checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL abort_buttons: got %h expected 00", buttons); end
      checks++; if (buttons_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", buttons_valid); end
      checks++; if (reg_rdata !== 8'hFF) begin errors++; $display("FAIL abort_rdata: got %h expected FF", reg_rdata); end
      reset_n = 1'b1;
      pad_pressed = 8'h41;
      first = -1;
      for (int n = 1; n <= 250 && first < 0; n++) begin
         tick();
         if (ctrl_strobe === 1'b1) first = n;
      end
      checks++; if (first != 200) begin errors++; $display("FAIL resume_start: got %0d expected 200", first); end
      checks++; if (valid_cnt != v0) begin errors++; $display("FAIL abort_no_commit: got %0d commits expected 0", valid_cnt - v0); end
      repeat (40) tick();
      checks++; if (buttons !== 8'h41) begin errors++; $display("FAIL resume_buttons: got %h expected 41", buttons); end
   endtask

   task automatic test_both_rows();
      int i0;
      write_sel(8'h00);
      checks++; if (reg_rdata !== 8'hCC) begin errors++; $display("FAIL rdata_sel00: got %h expected CC", reg_rdata); end
      tick();
      checks++; if (joypad_irq !== 1'b1) begin errors++; $display("FAIL irq_sel_write: got %b expected 1", joypad_irq); end
      repeat (2) tick();
      i0 = irq_cnt;
      write_sel(8'h30);
      checks++; if (reg_rdata !== 8'hFF) begin errors++; $display("FAIL rdata_sel11: got %h expected FF", reg_rdata); end
      repeat (3) tick();
      checks++; if (irq_cnt - i0 != 0) begin errors++; $display("FAIL irq_sel11: got %0d pulses expected 0", irq_cnt - i0); end
   endtask

   initial begin
      test_reset();
      test_idle_start();
      test_poll_a_right();
      test_irq_start();
      test_back_to_back();
      test_reset_mid_poll();
      test_both_rows();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
